ms_dma_fifo_ahbl: RTL and testbench

MS_DMA_FIFO_AHBL -- requirements
Module: ms_dma_fifo_ahbl

---
 rtl/ms_dma_fifo_ahbl.sv | 154 +++++++++++++++
 tb/tb_ms_dma_fifo_ahbl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ms_dma_fifo_ahbl.sv
// AHB-Lite programmable FIFO feeding a DMA consumer, with level request (DREQ) and IRQ.
// Define MS_DMA_FIFO_STALL_EN to stall full-FIFO DATA writes instead of dropping them (OVF).
module ms_dma_fifo_ahbl #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic [31:0] RD_DATA,
    output logic        RD_VALID,
    input  logic        RD_READY,
    output logic        DREQ,
    output logic        IRQ
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [LW-1:0] DEPTH_LV = LW'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, thr_q;
    logic          en_q, dreq_en_q, ovf_q, dreq_q;
    logic [1:0]    im_q;
    logic          ph_valid_q, ph_write_q;
    logic [7:0]    ph_addr_q;

    logic        full, empty, pop, push, flush, acc_wr, wr_fire, blocked, stall, ovf_set;
    logic        wr_data, wr_status, wr_thr, wr_ctrl, wr_im;
    logic [31:0] status;
    logic        unused_ahb;

    assign unused_ahb = ^{HADDR[31:8], HTRANS[0], HSIZE};

    assign full     = (level_q == DEPTH_LV);
    assign empty    = (level_q == '0);
    assign RD_VALID = en_q & ~empty;
    assign pop      = RD_VALID & RD_READY;
    assign acc_wr   = ph_valid_q & ph_write_q;

    // A DATA write that finds the FIFO full with no pop in the same cycle.
    assign blocked = acc_wr & (ph_addr_q == 8'h00) & en_q & full & ~pop;

`ifdef MS_DMA_FIFO_STALL_EN
    assign stall   = blocked;
    assign ovf_set = 1'b0;
`else
    assign stall   = 1'b0;
    assign ovf_set = blocked;
`endif

    assign HREADYOUT = ~stall;
    assign wr_fire   = acc_wr & ~stall;
    assign wr_data   = wr_fire & (ph_addr_q == 8'h00);
    assign wr_status = wr_fire & (ph_addr_q == 8'h04);
    assign wr_thr    = wr_fire & (ph_addr_q == 8'h08);
    assign wr_ctrl   = wr_fire & (ph_addr_q == 8'h0C);
    assign wr_im     = wr_fire & (ph_addr_q == 8'h10);
    assign flush     = wr_ctrl & HWDATA[2];
    assign push      = wr_data & en_q & (~full | pop);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ph_valid_q <= 1'b0;
            ph_write_q <= 1'b0;
            ph_addr_q  <= '0;
        end else if (HREADY) begin
            ph_valid_q <= HSEL & HTRANS[1];
            ph_write_q <= HWRITE;
            ph_addr_q  <= HADDR[7:0];
        end else if (!stall) begin
            ph_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      level_q <= level_q + LW'(1);
            else if (pop && !push) level_q <= level_q - LW'(1);
        end
    end

    // Storage carries no reset; RD_DATA is forced to zero while empty.
    always_ff @(posedge HCLK) begin
        if (push) mem[wr_ptr_q] <= HWDATA;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            en_q      <= 1'b0;
            dreq_en_q <= 1'b0;
            thr_q     <= '0;
            im_q      <= '0;
            ovf_q     <= 1'b0;
            dreq_q    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en_q      <= HWDATA[0];
                dreq_en_q <= HWDATA[1];
            end
            if (wr_thr) thr_q <= HWDATA[LW-1:0];
            if (wr_im)  im_q  <= HWDATA[1:0];
            if (ovf_set)                      ovf_q <= 1'b1;
            else if (wr_status && HWDATA[18]) ovf_q <= 1'b0;
            dreq_q <= en_q & dreq_en_q & ((DEPTH_LV - level_q) > thr_q);
        end
    end

    always_comb begin
        status         = '0;
        status[LW-1:0] = level_q;
        status[16]     = empty;
        status[17]     = full;
        status[18]     = ovf_q;
    end

    always_comb begin
        HRDATA = 32'hDEADBEEF;
        case (ph_addr_q)
            8'h00: HRDATA = '0;
            8'h04: HRDATA = status;
            8'h08: begin
                HRDATA         = '0;
                HRDATA[LW-1:0] = thr_q;
            end
            8'h0C: HRDATA = {30'b0, dreq_en_q, en_q};
            8'h10: HRDATA = {30'b0, im_q};
            default: ;
        endcase
    end

    assign RD_DATA = empty ? 32'h0 : mem[rd_ptr_q];
    assign DREQ    = dreq_q;
    assign IRQ     = en_q & ((im_q[0] & ovf_q) | (im_q[1] & empty));

endmodule

// File: tb/tb_ms_dma_fifo_ahbl.sv
// Directed self-checking bench for ms_dma_fifo_ahbl (DEPTH=16); honours MS_DMA_FIFO_STALL_EN.
module tb_ms_dma_fifo_ahbl;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic [31:0] RD_DATA;
    logic        RD_VALID;
    logic        RD_READY;
    logic        DREQ;
    logic        IRQ;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_drain [16];

    always #5 HCLK = ~HCLK;
    assign HREADY = HREADYOUT;

    ms_dma_fifo_ahbl #(.DEPTH(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
        .RD_READY(RD_READY), .DREQ(DREQ), .IRQ(IRQ)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Non-pipelined write; caller sits 1ns after a rising edge. rdy drives RD_READY in the data phase.
    task automatic ahb_write(input logic [7:0] a, input logic [31:0] d, input logic rdy);
        int n;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {24'h0, a};
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = d; RD_READY = rdy;
        n = 0;
        while (!HREADYOUT && n < 50) begin
            @(posedge HCLK); #1;
            n++;
        end
        if (n >= 50) check("hready_timeout", {31'b0, HREADYOUT}, 32'h1);
        @(posedge HCLK); #1;
        RD_READY = 1'b0;
    endtask

    task automatic ahb_read(input logic [7:0] a, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {24'h0, a};
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        d = HRDATA;
        @(posedge HCLK); #1;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] v;
        ahb_read(a, v);
        check(tag, v, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'b010; HWDATA = '0; RD_READY = 1'b0;

`ifdef MS_DMA_FIFO_STALL_EN
        for (int i = 0; i < 14; i++) exp_drain[i] = 32'h102 + i;
        exp_drain[14] = 32'hBBBB0017;
`else
        for (int i = 0; i < 15; i++) exp_drain[i] = 32'h101 + i;
`endif
        exp_drain[15] = 32'hAAAA0001;

        repeat (3) @(posedge HCLK);
        #1;
        check("rst_hreadyout", {31'b0, HREADYOUT}, 32'h1);
        check("rst_rd_valid", {31'b0, RD_VALID}, 32'h0);
        check("rst_dreq", {31'b0, DREQ}, 32'h0);
        check("rst_irq", {31'b0, IRQ}, 32'h0);
        check("rst_rd_data", RD_DATA, 32'h0);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        check("post_rst_rd_data", RD_DATA, 32'h0);
        rd_chk("rst_status", 8'h04, 32'h0001_0000);
        rd_chk("rst_thr", 8'h08, 32'h0);
        rd_chk("rst_ctrl", 8'h0C, 32'h0);
        rd_chk("unmapped", 8'h20, 32'hDEADBEEF);
        rd_chk("data_read", 8'h00, 32'h0);

        // DATA write while disabled is silently discarded
        ahb_write(8'h00, 32'h9999_9999, 1'b0);
        rd_chk("en0_discard", 8'h04, 32'h0001_0000);

        ahb_write(8'h0C, 32'h1, 1'b0);
        check("irq_im0", {31'b0, IRQ}, 32'h0);
        ahb_write(8'h10, 32'h2, 1'b0);
        check("irq_empty", {31'b0, IRQ}, 32'h1);
        ahb_write(8'h10, 32'h0, 1'b0);

        ahb_write(8'h00, 32'h1111_1111, 1'b0);
        ahb_write(8'h00, 32'h2222_2222, 1'b0);
        ahb_write(8'h00, 32'h3333_3333, 1'b0);
        ahb_write(8'h00, 32'h4444_4444, 1'b0);
        check("four_rd_data", RD_DATA, 32'h1111_1111);
        check("four_rd_valid", {31'b0, RD_VALID}, 32'h1);
        rd_chk("four_level", 8'h04, 32'h0000_0004);

        RD_READY = 1'b1;
        @(posedge HCLK); #1;
        RD_READY = 1'b0;
        check("pop_next_head", RD_DATA, 32'h2222_2222);
        rd_chk("pop_level", 8'h04, 32'h0000_0003);

        ahb_write(8'h0C, 32'h5, 1'b0);
        rd_chk("flush_status", 8'h04, 32'h0001_0000);
        check("flush_rd_valid", {31'b0, RD_VALID}, 32'h0);
        rd_chk("flush_reads0", 8'h0C, 32'h1);

        ahb_write(8'h08, 32'h3, 1'b0);
        ahb_write(8'h0C, 32'h3, 1'b0);
        rd_chk("thr_read", 8'h08, 32'h3);
        for (int i = 0; i < 12; i++) ahb_write(8'h00, 32'h100 + i, 1'b0);
        check("dreq_lvl12", {31'b0, DREQ}, 32'h1);
        ahb_write(8'h00, 32'h10C, 1'b0);
        check("dreq_lag", {31'b0, DREQ}, 32'h1);
        @(posedge HCLK); #1;
        check("dreq_lvl13", {31'b0, DREQ}, 32'h0);
        for (int i = 13; i < 16; i++) ahb_write(8'h00, 32'h100 + i, 1'b0);
        rd_chk("full_status", 8'h04, 32'h0002_0010);
        check("full_head", RD_DATA, 32'h100);

`ifdef MS_DMA_FIFO_STALL_EN
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hBBBB0017;
        check("stall_hready0", {31'b0, HREADYOUT}, 32'h0);
        @(posedge HCLK); #1;
        check("stall_hold", {31'b0, HREADYOUT}, 32'h0);
        RD_READY = 1'b1;
        #1;
        check("stall_release", {31'b0, HREADYOUT}, 32'h1);
        @(posedge HCLK); #1;
        RD_READY = 1'b0;
        rd_chk("stall_status", 8'h04, 32'h0002_0010);
        ahb_write(8'h10, 32'h1, 1'b0);
        check("stall_irq", {31'b0, IRQ}, 32'h0);
`else
        ahb_write(8'h00, 32'hBBBB0017, 1'b0);
        rd_chk("ovf_status", 8'h04, 32'h0006_0010);
        ahb_write(8'h10, 32'h1, 1'b0);
        check("ovf_irq", {31'b0, IRQ}, 32'h1);
`endif
        ahb_write(8'h04, 32'h0004_0000, 1'b0);
        rd_chk("ovf_clear", 8'h04, 32'h0002_0010);
        check("irq_cleared", {31'b0, IRQ}, 32'h0);

        // push and pop together at full
        ahb_write(8'h00, 32'hAAAA0001, 1'b1);
        rd_chk("pushpop_full", 8'h04, 32'h0002_0010);

        RD_READY = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain%0d", i), RD_DATA, exp_drain[i]);
            @(posedge HCLK); #1;
        end
        RD_READY = 1'b0;
        check("drain_rd_valid", {31'b0, RD_VALID}, 32'h0);
        rd_chk("drain_status", 8'h04, 32'h0001_0000);

        // pipelined DATA push immediately followed by a FLUSH write
        ahb_write(8'h00, 32'hC000_0001, 1'b0);
        ahb_write(8'h00, 32'hC000_0002, 1'b0);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
        @(posedge HCLK); #1;
        HADDR = 32'h0C; HWDATA = 32'hC000_0003;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h7;
        @(posedge HCLK); #1;
        rd_chk("push_flush_status", 8'h04, 32'h0001_0000);
        check("push_flush_valid", {31'b0, RD_VALID}, 32'h0);
        check("push_flush_data", RD_DATA, 32'h0);
        rd_chk("push_flush_ctrl", 8'h0C, 32'h3);

        // reset in the middle of a DATA write data phase
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hDEAD_0001;
        HRESETn = 1'b0;
        #2;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        rd_chk("midrst_status", 8'h04, 32'h0001_0000);
        rd_chk("midrst_ctrl", 8'h0C, 32'h0);
        check("midrst_valid", {31'b0, RD_VALID}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
